programmable_divider: RTL and testbench
=======================================

# programmable_divider

Programmable clock divider that turns the regulator's divisor into a divided reference waveform for the synchronizer loop. It sits directly downstream of the frequency regulator: its `div_in` is driven by the regulator's `adjustedDiv`, and its `div_out` feeds the phase comparison logic that generates PSI. New divisors are applied only at period boundaries, so `div_out` never shows a truncated or glitched period.

## Interface
- `WIDTH`, 8: width of the divisor, counter and `active_div`.
- `MIN_DIV`, 2: smallest divisor used; smaller `div_in` values are clamped up to this.
- `RST_DIV`, 8'b01111111: value of `active_div` after reset. It equals the regulator's reset divisor.

- `clk`  in  1  single system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  run request, level sensitive.
- `div_in`  in  WIDTH  requested divisor (from regulator `adjustedDiv`).
- `div_out`  out  1  divided waveform, registered.
- `tick`  out  1  one-cycle pulse in the first cycle of each period.
- `reload`  out  1  one-cycle pulse when the newly latched divisor differs from the previous one.
- `active_div`  out  WIDTH  divisor governing the current period.
- `count`  out  WIDTH  position within the current period, 0..`active_div`-1.

## Operation
- Clamped divisor: Dc = (`div_in` < `MIN_DIV`) ? `MIN_DIV` : `div_in`.
- High time: H = (`active_div`+1)>>1, computed at WIDTH+1 bits (ceil of D/2).
- Waveform: `div_out`=1 while `count` < H, otherwise 0.
  - D=5: 3 cycles high, 2 low.
  - D=2: 1 high, 1 low.
  - D=255: 128 high, 127 low.
- Reset: state=IDLE, `count`=0, `div_out`=0, `tick`=0, `reload`=0, `active_div`=`RST_DIV`.
- State IDLE:
  - `count` held at 0, `div_out`=0.
  - If `en`=1 at an edge: go to RUN; `active_div`<=Dc; `count`<=0; `tick`<=1; `div_out`<=1.
  - On that start, `reload`<=1 if Dc differs from `active_div`.
- State RUN:
  - `count` increments by 1 each cycle.
  - Terminal cycle is `count`==`active_div`-1. At that edge:
    - `count`<=0, `tick`<=1.
    - `active_div`<=Dc, with `div_in` sampled in the terminal cycle.
    - `reload`<=1 iff Dc != old `active_div`.
  - If `en`=0 in any RUN cycle, go to STOP. `count` keeps advancing and the current period completes.
- State STOP (draining):
  - `count` keeps advancing.
  - If `en` returns to 1 before the terminal cycle, go back to RUN with no gap.
  - At the terminal edge with `en`=0: go to IDLE, `count`<=0, `div_out`<=0, no `tick`, `active_div` unchanged.
  - At the terminal edge with `en`=1: behave as the RUN terminal edge and go to RUN.
- `div_in` is ignored outside the start edge and terminal edges. Mid-period changes never alter the current period.
- `count` cannot overflow, since `active_div` ≤ 2^WIDTH−1 and `count` < `active_div`.
- `rst` overrides everything, including mid-period and in STOP. The next edge yields the reset values.

## Timing
- All outputs come from flops; no combinational input-to-output paths.
- Start latency: `en` sampled high at edge t gives `tick`=1, `count`=0, `div_out`=1 in the cycle after t.
- Each period is exactly `active_div` cycles, and `tick` period equals `active_div`.
- Divisor update latency: a new `div_in` takes effect at the next period start, at most `active_div` cycles later.
- `reload` coincides with the `tick` of the period that uses the new divisor.
- Stop latency: `div_out` returns to 0 and stays low from the first cycle after the terminal cycle of the period in which `en` fell.
- If `div_in` changes in the terminal cycle itself, the new value is used.

## Test plan
- Reset then idle: with `rst`=1 for 2 cycles and `en`=0, outputs must be `div_out`=0, `tick`=0, `reload`=0, `count`=0, `active_div`=127 and must hold.
- Steady D=4: `en`=1 → `tick` every 4 cycles; `div_out` pattern 1100 repeating; `count` sequence 0,1,2,3; `reload` pulses once at start (127→4).
- Odd D=5, then D=255: `div_out` is 3 high / 2 low, then 128 high / 127 low; `tick` spacing 5, then 255.
- Mid-period change: D=4 running, `div_in`→6 at `count`=1 → remainder of the current period stays 4 cycles; next period is 6 cycles (111000); `reload` pulses with that `tick`; no pulse in later periods.
- Clamp: `div_in`=0, then 1 → `active_div`=2; `div_out` toggles 1,0; `tick` every 2 cycles.
- Stop and reset:
  - `en`→0 at `count`=1 of D=6 → period finishes at `count`=5, then `div_out`=0 with no further `tick`.
  - `en` re-raised at `count`=3 → continuous periods.
  - `rst` at `count`=2 → reset values on the next edge.

Source files
------------

// File: rtl/programmable_divider.sv
// ============================================================================
// Module   : programmable_divider
// Purpose  : Divides clk by a divisor latched only at period boundaries,
//            producing a glitch-free divided waveform plus tick/reload pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module programmable_divider #(
    parameter int               WIDTH   = 8,
    parameter int               MIN_DIV = 2,
    parameter logic [WIDTH-1:0] RST_DIV = 8'b01111111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    output logic             div_out,
    output logic             tick,
    output logic             reload,
    output logic [WIDTH-1:0] active_div,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_min_div = WIDTH'(MIN_DIV);
    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] w_dc;
    logic [WIDTH:0]   w_high;
    logic [WIDTH-1:0] w_count_inc;
    logic             w_terminal;
    logic             w_next_high;

    always_comb begin
        w_dc        = (div_in < c_min_div) ? c_min_div : div_in;
        // High time is ceil(D/2); the extra bit keeps D = 2^WIDTH-1 exact.
        w_high      = ({1'b0, active_div} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
        w_count_inc = count + c_one;
        w_terminal  = (count == (active_div - c_one));
        w_next_high = ({1'b0, w_count_inc} < w_high);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            count      <= '0;
            div_out    <= 1'b0;
            tick       <= 1'b0;
            reload     <= 1'b0;
            active_div <= RST_DIV;
        end else begin
            tick   <= 1'b0;
            reload <= 1'b0;
            case (r_state)
                IDLE: begin
                    count   <= '0;
                    div_out <= 1'b0;
                    if (en) begin
                        r_state    <= RUN;
                        active_div <= w_dc;
                        reload     <= (w_dc != active_div);
                        tick       <= 1'b1;
                        div_out    <= 1'b1;
                    end
                end
                RUN, STOP: begin
                    if (w_terminal) begin
                        count <= '0;
                        if (en) begin
                            r_state    <= RUN;
                            active_div <= w_dc;
                            reload     <= (w_dc != active_div);
                            tick       <= 1'b1;
                            div_out    <= 1'b1;
                        end else begin
                            // Period in which en fell has completed: park low.
                            r_state <= IDLE;
                            div_out <= 1'b0;
                        end
                    end else begin
                        count   <= w_count_inc;
                        div_out <= w_next_high;
                        r_state <= en ? RUN : STOP;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    count   <= '0;
                    div_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_programmable_divider.sv
// ============================================================================
// Module   : tb_programmable_divider
// Purpose  : Self-checking bench comparing the divider against a period-level
//            reference model under directed and randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_programmable_divider;

    localparam int WIDTH   = 8;
    localparam int MIN_DIV = 2;
    localparam int RST_DIV = 127;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] div_in;
    logic             div_out;
    logic             tick;
    logic             reload;
    logic [WIDTH-1:0] active_div;
    logic [WIDTH-1:0] count;

    int checks = 0;
    int errors = 0;

    // Reference model: a period is either in progress or not; no state codes.
    bit m_running;
    int m_pos;
    int m_div;
    bit m_tick;
    bit m_reload;

    programmable_divider #(
        .WIDTH   (WIDTH),
        .MIN_DIV (MIN_DIV),
        .RST_DIV (8'b01111111)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .div_in     (div_in),
        .div_out    (div_out),
        .tick       (tick),
        .reload     (reload),
        .active_div (active_div),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int clamp(input int d);
        return (d < MIN_DIV) ? MIN_DIV : d;
    endfunction

    task automatic start_period();
        int d;
        d         = clamp(int'(div_in));
        m_reload  = (d != m_div);
        m_div     = d;
        m_pos     = 0;
        m_tick    = 1'b1;
        m_running = 1'b1;
    endtask

    task automatic model_step();
        m_tick   = 1'b0;
        m_reload = 1'b0;
        if (rst) begin
            m_running = 1'b0;
            m_pos     = 0;
            m_div     = RST_DIV;
        end else if (!m_running) begin
            if (en) start_period();
        end else if (m_pos == m_div - 1) begin
            if (en) start_period();
            else begin
                m_running = 1'b0;
                m_pos     = 0;
            end
        end else begin
            m_pos++;
        end
    endtask

    task automatic cycle();
        int high;
        @(posedge clk);
        model_step();
        @(negedge clk);
        high = (m_div + 1) / 2;
        check_value("count",      int'(count),      m_pos);
        check_value("active_div", int'(active_div), m_div);
        check_value("tick",       int'(tick),       int'(m_tick));
        check_value("reload",     int'(reload),     int'(m_reload));
        check_value("div_out",    int'(div_out),    (m_running && m_pos < high) ? 1 : 0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_pos(input int pos);
        int budget;
        budget = 600;
        while (!(m_running && m_pos == pos) && budget > 0) begin
            cycle();
            budget--;
        end
        if (budget == 0) check_value("wait_timeout", 0, 1);
    endtask

    initial begin
        int ticks_seen;
        rst    = 1'b1;
        en     = 1'b0;
        div_in = 8'd4;
        m_running = 1'b0;
        m_pos     = 0;
        m_div     = RST_DIV;
        m_tick    = 1'b0;
        m_reload  = 1'b0;
        @(negedge clk);

        run(2);
        rst = 1'b0;
        run(4);

        en = 1'b1;
        run(13);

        div_in = 8'd5;
        run(16);
        div_in = 8'd255;
        run(520);

        div_in = 8'd4;
        run(9);
        run_until_pos(1);
        div_in = 8'd6;
        run(20);

        div_in = 8'd0;
        run(12);
        div_in = 8'd1;
        run(8);

        div_in = 8'd6;
        run(8);
        run_until_pos(1);
        en = 1'b0;
        ticks_seen = 0;
        for (int i = 0; i < 14; i++) begin
            cycle();
            if (tick) ticks_seen++;
        end
        check_value("no_tick_after_stop", ticks_seen, 0);

        en = 1'b1;
        run(3);
        run_until_pos(1);
        en = 1'b0;
        run_until_pos(3);
        en = 1'b1;
        run(15);

        run_until_pos(2);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(6);

        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 9) == 0) div_in = WIDTH'($urandom_range(0, 12));
            if ($urandom_range(0, 15) == 0) en = ~en;
            rst = ($urandom_range(0, 299) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
